// File: rtl/io_port_buf.sv
// Buffered tristate I/O port: DEPTH-entry receive FIFO, one-word transmit register.
// Optional status word on the bus when IOPORT_STATUS_EN is defined (adds sEn).
module io_port_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             rEn,
  input  logic             wEn,
`ifdef IOPORT_STATUS_EN
  input  logic             sEn,
`endif
  input  logic [WIDTH-1:0] dataIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] dataOut,
  output logic             outValid,
  input  logic             outReady,
  output logic             overrun,
  output logic             underrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;

  logic             full;
  logic             empty;
  logic             rd;
  logic             push;
  logic             pop;
  logic             ur_evt;
  logic             ov_evt;
  logic             stat_rd;
  logic             drive;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] bus_q;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign inReady = !full;

  // a write owns the bus, so it suppresses any read in the same cycle
  assign rd     = rEn & ~wEn;
  assign push   = inValid & ~full;
  assign pop    = rd & ~empty;
  assign ur_evt = rd & empty;
  assign ov_evt = wEn & outValid & ~outReady;
  assign rdata  = empty ? '0 : mem[rptr];

`ifdef IOPORT_STATUS_EN
  logic [CW+4:0]    sword;
  logic [WIDTH-1:0] stat;

  assign sword   = {count, full, empty, outValid, overrun, underrun};
  assign stat    = WIDTH'(sword);
  assign stat_rd = sEn & ~rEn & ~wEn;
  assign drive   = rd | stat_rd;
  assign bus_q   = rd ? rdata : stat;
`else
  assign stat_rd = 1'b0;
  assign drive   = rd;
  assign bus_q   = rdata;
`endif

  assign bus = drive ? bus_q : {WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= dataIn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataOut  <= '0;
      outValid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (wEn) begin
        dataOut  <= bus;
        outValid <= 1'b1;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end
      overrun  <= ov_evt | (overrun & ~stat_rd);
      underrun <= ur_evt | (underrun & ~stat_rd);
    end
  end

endmodule

// File: tb/tb_io_port_buf.sv
// Randomised and directed bench for io_port_buf.
// Queue-based reference model checked every cycle on the falling edge.
module tb_io_port_buf;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rEn = 1'b0;
  logic         wEn = 1'b0;
  logic         sEn = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic         inValid = 1'b0;
  logic         outReady = 1'b0;
  logic [W-1:0] tb_val = '0;
  wire  [W-1:0] bus;
  logic         inReady;
  logic [W-1:0] dataOut;
  logic         outValid;
  logic         overrun;
  logic         underrun;

  int vectors = 0;
  int miscompares = 0;

  assign bus = wEn ? tb_val : {W{1'bz}};

  always #5 clk = ~clk;

  io_port_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rEn      (rEn),
    .wEn      (wEn),
`ifdef IOPORT_STATUS_EN
    .sEn      (sEn),
`endif
    .dataIn   (dataIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .dataOut  (dataOut),
    .outValid (outValid),
    .outReady (outReady),
    .overrun  (overrun),
    .underrun (underrun)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_ov;
  logic         m_ovr;
  logic         m_udr;
  logic         m_rd;
  logic         m_srd;
  logic         m_pop;
  logic         m_push;
  logic         m_urev;
  logic         m_ovev;
  int           m_stat;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_dout = '0;
      m_ov   = 1'b0;
      m_ovr  = 1'b0;
      m_udr  = 1'b0;
    end else begin
      m_rd = rEn && !wEn;
`ifdef IOPORT_STATUS_EN
      m_srd = sEn && !rEn && !wEn;
`else
      m_srd = 1'b0;
`endif
      chk("inReady", 32'(inReady), 32'(q.size() < D));
      chk("dataOut", 32'(dataOut), 32'(m_dout));
      chk("outValid", 32'(outValid), 32'(m_ov));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("underrun", 32'(underrun), 32'(m_udr));
      if (m_rd)
        chk("bus_read", 32'(bus), (q.size() > 0) ? 32'(q[0]) : 32'h0);
      if (m_srd) begin
        m_stat = (q.size() << 5) | (int'(q.size() == D) << 4) |
                 (int'(q.size() == 0) << 3) | (int'(m_ov) << 2) |
                 (int'(m_ovr) << 1) | int'(m_udr);
        chk("bus_status", 32'(bus), 32'(m_stat & 'hFFFF));
      end
      m_pop  = m_rd && q.size() > 0;
      m_urev = m_rd && q.size() == 0;
      m_push = inValid && q.size() < D;
      m_ovev = wEn && m_ov && !outReady;
      if (m_pop)
        void'(q.pop_front());
      if (m_push)
        q.push_back(dataIn);
      if (wEn) begin
        m_dout = tb_val;
        m_ov   = 1'b1;
      end else if (m_ov && outReady) begin
        m_ov = 1'b0;
      end
      m_ovr = m_ovev || (m_ovr && !m_srd);
      m_udr = m_urev || (m_udr && !m_srd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rEn = 1'b0; wEn = 1'b0; sEn = 1'b0;
    inValid = 1'b0; outReady = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [W-1:0] v);
    inValid = 1'b1; dataIn = v;
    step();
    inValid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] fill [4];
    fill[0] = 16'h1111; fill[1] = 16'h2222;
    fill[2] = 16'h3333; fill[3] = 16'h4444;

    do_reset();
    chk("rst_inReady", 32'(inReady), 32'h1);
    chk("rst_outValid", 32'(outValid), 32'h0);
    chk("rst_dataOut", 32'(dataOut), 32'h0);
    chk("rst_flags", {30'h0, overrun, underrun}, 32'h0);

    // fill to full, then drain in order
    for (int i = 0; i < 4; i++) push(fill[i]);
    chk("full_inReady", 32'(inReady), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rEn = 1'b1;
      #1 chk("drain_bus", 32'(bus), 32'(fill[i]));
      step();
    end
    rEn = 1'b0;
    #1 chk("drained_inReady", 32'(inReady), 32'h1);

    // underrun on empty
    rEn = 1'b1;
    #1 chk("ur_bus", 32'(bus), 32'h0);
    step();
    rEn = 1'b0;
    chk("ur_flag", 32'(underrun), 32'h1);
    step();
    chk("ur_sticky", 32'(underrun), 32'h1);
    chk("ur_inReady", 32'(inReady), 32'h1);

    // simultaneous push/pop at count 2 across wrap
    push(16'h0100);
    push(16'h0101);
    for (int k = 0; k < 10; k++) begin
      inValid = 1'b1; dataIn = 16'(16'h0102 + k); rEn = 1'b1;
      #1 chk("pp_bus", 32'(bus), 32'(16'h0100 + k));
      step();
    end
    inValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rEn = 1'b1;
      #1 chk("pp_tail", 32'(bus), 32'(16'h010A + k));
      step();
    end
    rEn = 1'b0;

    // transmit overrun
    do_reset();
    wEn = 1'b1; tb_val = 16'hAAAA; step();
    tb_val = 16'h5555; step();
    wEn = 1'b0;
    chk("ov_dataOut", 32'(dataOut), 32'h5555);
    chk("ov_flag", 32'(overrun), 32'h1);
    chk("ov_valid", 32'(outValid), 32'h1);

    // second write consumed in the same edge: no overrun
    do_reset();
    wEn = 1'b1; tb_val = 16'hAAAA; step();
    tb_val = 16'h5555; outReady = 1'b1; step();
    wEn = 1'b0;
    chk("nov_dataOut", 32'(dataOut), 32'h5555);
    chk("nov_flag", 32'(overrun), 32'h0);
    step();
    outReady = 1'b0;
    chk("consume_valid", 32'(outValid), 32'h0);
    chk("consume_hold", 32'(dataOut), 32'h5555);

`ifdef IOPORT_STATUS_EN
    do_reset();
    rEn = 1'b1; step(); rEn = 1'b0;
    push(16'h0001); push(16'h0002); push(16'h0003);
    sEn = 1'b1;
    #1 chk("status_word", 32'(bus), 32'h0061);
    step();
    sEn = 1'b0;
    chk("status_clear", 32'(underrun), 32'h0);
`endif

    // async reset mid-burst
    do_reset();
    wEn = 1'b1; tb_val = 16'h1234; step(); wEn = 1'b0;
    rEn = 1'b1; step(); rEn = 1'b0;
    push(16'h0A0A); push(16'h0B0B);
    rst_n = 1'b0;
    #1;
    chk("arst_outValid", 32'(outValid), 32'h0);
    chk("arst_dataOut", 32'(dataOut), 32'h0);
    chk("arst_underrun", 32'(underrun), 32'h0);
    chk("arst_inReady", 32'(inReady), 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    rEn = 1'b1;
    #1 chk("arst_empty_bus", 32'(bus), 32'h0);
    step();
    rEn = 1'b0;

    // randomised traffic
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rEn      = ($urandom_range(0, 99) < 35);
      wEn      = ($urandom_range(0, 99) < 20);
      sEn      = ($urandom_range(0, 99) < 10);
      inValid  = ($urandom_range(0, 99) < 50);
      outReady = ($urandom_range(0, 99) < 50);
      dataIn   = W'($urandom);
      tb_val   = W'($urandom);
      if (n % 500 == 499) begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
